// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: funct3 encodings, FSM states
// and the byte-lane helpers used when issuing a data-memory request.
package mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    function automatic logic [3:0] byte_enable(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            F3_B, F3_BU: byte_enable = 4'b0001 << off;
            F3_H, F3_HU: byte_enable = 4'b0011 << off;
            default:     byte_enable = 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        is_misaligned = ((funct3 == F3_W) && (off != 2'b00)) ||
                        (((funct3 == F3_H) || (funct3 == F3_HU)) && off[0]);
    endfunction

    // Replicate the store operand into every lane so the byte enables alone pick the target.
    function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] data);
        case (funct3)
            F3_B, F3_BU: store_lanes = {4{data[7:0]}};
            F3_H, F3_HU: store_lanes = {2{data[15:0]}};
            default:     store_lanes = data;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: selects the addressed byte/half of a read word
// and sign- or zero-extends it according to funct3.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = rdata[{offset[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'h0, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'h0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues loads/stores over a single-outstanding
// req/ack bus, aligns load data and registers the writeback payload.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter  int DATA_WIDTH     = 32,  // byte-lane logic assumes exactly 32
    parameter  int REG_FILE_DEPTH = 32,
    parameter  int TIMEOUT_CYCLES = 16,
    localparam int REG_FILE_ADDR  = $clog2(REG_FILE_DEPTH)
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_valid,
    input  logic                     i_ctrl_mem_read,
    input  logic                     i_ctrl_mem_write,
    input  logic [2:0]               i_ctrl_funct3,
    input  logic                     i_ctrl_reg_write,
    input  logic [REG_FILE_ADDR-1:0] i_rd_addr,
    input  logic [DATA_WIDTH-1:0]    i_IE_result,
    input  logic [DATA_WIDTH-1:0]    i_IE_data_write,
    output logic                     o_stall,
    output logic                     o_dmem_req,
    output logic                     o_dmem_we,
    output logic [DATA_WIDTH-1:0]    o_dmem_addr,
    output logic [DATA_WIDTH-1:0]    o_dmem_wdata,
    output logic [3:0]               o_dmem_be,
    input  logic                     i_dmem_ack,
    input  logic [DATA_WIDTH-1:0]    i_dmem_rdata,
    output logic                     o_MEM_valid,
    output logic [DATA_WIDTH-1:0]    o_MEM_result,
    output logic [REG_FILE_ADDR-1:0] o_MEM_rd_addr,
    output logic                     o_MEM_reg_write,
    output logic                     o_MEM_misaligned,
    output logic                     o_MEM_bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         cnt;
    logic [2:0]               lat_funct3;
    logic [1:0]               lat_off;
    logic [REG_FILE_ADDR-1:0] lat_rd;
    logic                     lat_reg_write;
    logic                     lat_read;
    logic [DATA_WIDTH-1:0]    load_data;
    logic                     stall_c;

    // Read wins when both read and write are asserted.
    logic is_read, is_write, mem_op, misaligned, accept, terminal;
    assign is_read    = i_ctrl_mem_read;
    assign is_write   = i_ctrl_mem_write & ~i_ctrl_mem_read;
    assign mem_op     = is_read | is_write;
    assign misaligned = is_misaligned(i_ctrl_funct3, i_IE_result[1:0]);
    assign accept     = (state == IDLE) & i_valid & mem_op & ~misaligned;
    assign terminal   = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    load_align u_load_align (
        .funct3 (lat_funct3),
        .offset (lat_off),
        .rdata  (i_dmem_rdata),
        .result (load_data)
    );

    always_comb begin
        state_nxt = state;
        stall_c   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = BUS;
                    stall_c   = 1'b1;
                end
            end
            BUS: begin
                if (i_dmem_ack || terminal) begin
                    state_nxt = IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Gating with reset lets the stall drop immediately, even if execute still presents a mem op.
    assign o_stall    = i_reset_n & stall_c;
    assign o_dmem_req = (state == BUS);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if ((state == BUS) && !i_dmem_ack && !terminal) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

    // Request latch: bus signals stay frozen for the whole BUS phase.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_dmem_we     <= 1'b0;
            o_dmem_addr   <= '0;
            o_dmem_wdata  <= '0;
            o_dmem_be     <= '0;
            lat_funct3    <= '0;
            lat_off       <= '0;
            lat_rd        <= '0;
            lat_reg_write <= 1'b0;
            lat_read      <= 1'b0;
        end else if (accept) begin
            o_dmem_we     <= is_write;
            o_dmem_addr   <= {i_IE_result[DATA_WIDTH-1:2], 2'b00};
            o_dmem_wdata  <= store_lanes(i_ctrl_funct3, i_IE_data_write);
            o_dmem_be     <= is_write ? byte_enable(i_ctrl_funct3, i_IE_result[1:0]) : 4'b0000;
            lat_funct3    <= i_ctrl_funct3;
            lat_off       <= i_IE_result[1:0];
            lat_rd        <= i_rd_addr;
            lat_reg_write <= i_ctrl_reg_write;
            lat_read      <= is_read;
        end
    end

    // Writeback register: exception flags pulse only alongside a valid payload.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_MEM_valid      <= 1'b0;
            o_MEM_result     <= '0;
            o_MEM_rd_addr    <= '0;
            o_MEM_reg_write  <= 1'b0;
            o_MEM_misaligned <= 1'b0;
            o_MEM_bus_err    <= 1'b0;
        end else begin
            o_MEM_valid      <= 1'b0;
            o_MEM_misaligned <= 1'b0;
            o_MEM_bus_err    <= 1'b0;
            if (state == IDLE) begin
                if (i_valid && !mem_op) begin
                    o_MEM_valid     <= 1'b1;
                    o_MEM_result    <= i_IE_result;
                    o_MEM_rd_addr   <= i_rd_addr;
                    o_MEM_reg_write <= i_ctrl_reg_write;
                end else if (i_valid && misaligned) begin
                    o_MEM_valid      <= 1'b1;
                    o_MEM_misaligned <= 1'b1;
                    o_MEM_result     <= '0;
                    o_MEM_rd_addr    <= i_rd_addr;
                    o_MEM_reg_write  <= 1'b0;
                end
            end else if (i_dmem_ack) begin
                o_MEM_valid     <= 1'b1;
                o_MEM_result    <= lat_read ? load_data : '0;
                o_MEM_rd_addr   <= lat_rd;
                o_MEM_reg_write <= lat_reg_write & lat_read;
            end else if (terminal) begin
                o_MEM_valid     <= 1'b1;
                o_MEM_bus_err   <= 1'b1;
                o_MEM_result    <= '0;
                o_MEM_rd_addr   <= lat_rd;
                o_MEM_reg_write <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: scenario tasks drive execute-side stimulus and a
// bus responder; expected writeback payloads are queued and checked on o_MEM_valid.
module tb_mem_access_stage;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ctrl_mem_read = 1'b0;
    logic        i_ctrl_mem_write = 1'b0;
    logic [2:0]  i_ctrl_funct3 = 3'b000;
    logic        i_ctrl_reg_write = 1'b0;
    logic [4:0]  i_rd_addr = 5'd0;
    logic [31:0] i_IE_result = 32'h0;
    logic [31:0] i_IE_data_write = 32'h0;
    logic        o_stall;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_ack = 1'b0;
    logic [31:0] i_dmem_rdata = 32'h0;
    logic        o_MEM_valid;
    logic [31:0] o_MEM_result;
    logic [4:0]  o_MEM_rd_addr;
    logic        o_MEM_reg_write;
    logic        o_MEM_misaligned;
    logic        o_MEM_bus_err;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        reg_write;
        logic        misaligned;
        logic        bus_err;
    } wb_t;

    wb_t sb_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    mem_access_stage dut (
        .i_clk            (i_clk),
        .i_reset_n        (i_reset_n),
        .i_valid          (i_valid),
        .i_ctrl_mem_read  (i_ctrl_mem_read),
        .i_ctrl_mem_write (i_ctrl_mem_write),
        .i_ctrl_funct3    (i_ctrl_funct3),
        .i_ctrl_reg_write (i_ctrl_reg_write),
        .i_rd_addr        (i_rd_addr),
        .i_IE_result      (i_IE_result),
        .i_IE_data_write  (i_IE_data_write),
        .o_stall          (o_stall),
        .o_dmem_req       (o_dmem_req),
        .o_dmem_we        (o_dmem_we),
        .o_dmem_addr      (o_dmem_addr),
        .o_dmem_wdata     (o_dmem_wdata),
        .o_dmem_be        (o_dmem_be),
        .i_dmem_ack       (i_dmem_ack),
        .i_dmem_rdata     (i_dmem_rdata),
        .o_MEM_valid      (o_MEM_valid),
        .o_MEM_result     (o_MEM_result),
        .o_MEM_rd_addr    (o_MEM_rd_addr),
        .o_MEM_reg_write  (o_MEM_reg_write),
        .o_MEM_misaligned (o_MEM_misaligned),
        .o_MEM_bus_err    (o_MEM_bus_err)
    );

    always #5 i_clk = ~i_clk;

    // Scoreboard monitor: every writeback pulse must match the oldest queued expectation.
    always @(negedge i_clk) begin
        if (o_MEM_valid === 1'b1) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid: got result=%h rd=%0d with no expected entry",
                         o_MEM_result, o_MEM_rd_addr);
            end else begin
                wb_t e;
                wb_t g;
                e = sb_q.pop_front();
                g = '{o_MEM_result, o_MEM_rd_addr, o_MEM_reg_write, o_MEM_misaligned, o_MEM_bus_err};
                if (g !== e) begin
                    n_err++;
                    $display("FAIL wb_payload: got res=%h rd=%0d rw=%b mis=%b err=%b, want res=%h rd=%0d rw=%b mis=%b err=%b",
                             g.result, g.rd, g.reg_write, g.misaligned, g.bus_err,
                             e.result, e.rd, e.reg_write, e.misaligned, e.bus_err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic rw, input logic [4:0] rd);
        i_valid          = 1'b1;
        i_ctrl_mem_read  = rd_en;
        i_ctrl_mem_write = wr_en;
        i_ctrl_funct3    = f3;
        i_IE_result      = addr;
        i_IE_data_write  = wd;
        i_ctrl_reg_write = rw;
        i_rd_addr        = rd;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge i_clk);
        n_cmp++;
        if ({o_MEM_valid, o_dmem_req, o_stall, o_dmem_we, o_dmem_be} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_ctrl: got valid=%b req=%b stall=%b we=%b be=%b want all 0",
                     o_MEM_valid, o_dmem_req, o_stall, o_dmem_we, o_dmem_be);
        end
        n_cmp++;
        if ({o_MEM_result, o_dmem_addr, o_dmem_wdata} !== 96'h0) begin
            n_err++;
            $display("FAIL reset_data: got result=%h addr=%h wdata=%h want 0",
                     o_MEM_result, o_dmem_addr, o_dmem_wdata);
        end
        @(posedge i_clk);
        #1 i_reset_n = 1'b1;
    endtask

    // Back-to-back ALU pass-through ops, one per cycle, never stalling.
    task automatic test_alu_pass();
        logic [31:0] vals[3] = '{32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0000};
        logic [4:0]  rds[3]  = '{5'd5, 5'd31, 5'd0};
        logic        rws[3]  = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            drive_op(1'b0, 1'b0, 3'b010, vals[i], 32'hA5A5_A5A5, rws[i], rds[i]);
            sb_q.push_back('{vals[i], rds[i], rws[i], 1'b0, 1'b0});
            @(negedge i_clk);
            n_cmp++;
            if (o_stall !== 1'b0 || o_dmem_req !== 1'b0) begin
                n_err++;
                $display("FAIL alu_stall: got stall=%b req=%b want 0/0", o_stall, o_dmem_req);
            end
            tick();
        end
        i_valid = 1'b0;
        tick();
    endtask

    // One aligned memory access: accept cycle, then `waits` ack-less BUS cycles, then ack.
    task automatic run_mem_access(input string name, input logic rd_en, input logic wr_en,
                                  input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [31:0] rdata,
                                  input int waits, input logic rw, input logic [4:0] rd,
                                  input logic exp_we, input logic [3:0] exp_be,
                                  input logic [31:0] exp_wdata, input wb_t exp_wb);
        int stall_cycles = 0;
        drive_op(rd_en, wr_en, f3, addr, wd, rw, rd);
        sb_q.push_back(exp_wb);
        @(negedge i_clk);
        n_cmp++;
        if (o_stall !== 1'b1 || o_dmem_req !== 1'b0) begin
            n_err++;
            $display("FAIL %s_accept: got stall=%b req=%b want 1/0", name, o_stall, o_dmem_req);
        end
        if (o_stall === 1'b1) stall_cycles++;
        tick();
        for (int w = 0; w <= waits; w++) begin
            if (w == waits) begin
                i_dmem_ack   = 1'b1;
                i_dmem_rdata = rdata;
            end else begin
                i_dmem_rdata = 32'hDEAD_0000 + w;
            end
            @(negedge i_clk);
            n_cmp++;
            if (o_dmem_req !== 1'b1 || o_dmem_addr !== (addr & 32'hFFFF_FFFC) ||
                o_dmem_we !== exp_we || o_dmem_be !== exp_be ||
                (exp_we && o_dmem_wdata !== exp_wdata)) begin
                n_err++;
                $display("FAIL %s_bus[%0d]: got req=%b addr=%h we=%b be=%b wdata=%h want 1 %h %b %b %h",
                         name, w, o_dmem_req, o_dmem_addr, o_dmem_we, o_dmem_be, o_dmem_wdata,
                         addr & 32'hFFFF_FFFC, exp_we, exp_be, exp_wdata);
            end
            if (o_stall === 1'b1) stall_cycles++;
            tick();
        end
        i_dmem_ack = 1'b0;
        i_valid    = 1'b0;
        n_cmp++;
        if (stall_cycles != waits + 1) begin
            n_err++;
            $display("FAIL %s_stall_len: got %0d stall cycles want %0d", name, stall_cycles, waits + 1);
        end
        tick();
    endtask

    task automatic test_loads();
        run_mem_access("lb", 1, 0, 3'b000, 32'h103, 0, 32'h80AA_BBCC, 0, 1, 5'd7,
                       0, 4'b0000, 0, '{32'hFFFF_FF80, 5'd7, 1'b1, 1'b0, 1'b0});
        run_mem_access("lbu", 1, 0, 3'b100, 32'h103, 0, 32'h80AA_BBCC, 0, 1, 5'd8,
                       0, 4'b0000, 0, '{32'h0000_0080, 5'd8, 1'b1, 1'b0, 1'b0});
        run_mem_access("lb0", 1, 0, 3'b000, 32'h100, 0, 32'h80AA_BBCC, 1, 0, 5'd9,
                       0, 4'b0000, 0, '{32'hFFFF_FFCC, 5'd9, 1'b0, 1'b0, 1'b0});
        run_mem_access("lh", 1, 0, 3'b001, 32'h102, 0, 32'h80AA_BBCC, 2, 1, 5'd10,
                       0, 4'b0000, 0, '{32'hFFFF_80AA, 5'd10, 1'b1, 1'b0, 1'b0});
        run_mem_access("lhu", 1, 0, 3'b101, 32'h102, 0, 32'h80AA_BBCC, 0, 1, 5'd11,
                       0, 4'b0000, 0, '{32'h0000_80AA, 5'd11, 1'b1, 1'b0, 1'b0});
        run_mem_access("lw", 1, 0, 3'b010, 32'h104, 0, 32'h89AB_CDEF, 0, 1, 5'd12,
                       0, 4'b0000, 0, '{32'h89AB_CDEF, 5'd12, 1'b1, 1'b0, 1'b0});
        run_mem_access("rw_both", 1, 1, 3'b010, 32'h600, 32'h1111_2222, 32'h0BAD_F00D, 0, 1, 5'd13,
                       0, 4'b0000, 0, '{32'h0BAD_F00D, 5'd13, 1'b1, 1'b0, 1'b0});
        run_mem_access("lw_ack_last", 1, 0, 3'b010, 32'h700, 0, 32'h7777_0001, 15, 1, 5'd14,
                       0, 4'b0000, 0, '{32'h7777_0001, 5'd14, 1'b1, 1'b0, 1'b0});
    endtask

    task automatic test_stores();
        run_mem_access("sh", 0, 1, 3'b001, 32'h202, 32'hDEAD_BEEF, 32'h0, 3, 1, 5'd3,
                       1, 4'b1100, 32'hBEEF_BEEF, '{32'h0, 5'd3, 1'b0, 1'b0, 1'b0});
        run_mem_access("sb", 0, 1, 3'b000, 32'h201, 32'h1122_3344, 32'h0, 0, 0, 5'd4,
                       1, 4'b0010, 32'h4444_4444, '{32'h0, 5'd4, 1'b0, 1'b0, 1'b0});
        run_mem_access("sw", 0, 1, 3'b010, 32'h500, 32'hCAFE_F00D, 32'h0, 1, 1, 5'd6,
                       1, 4'b1111, 32'hCAFE_F00D, '{32'h0, 5'd6, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic test_misaligned();
        logic [31:0] addrs[3] = '{32'h101, 32'h203, 32'h302};
        logic [2:0]  f3s[3]   = '{3'b010, 3'b001, 3'b010};
        logic        wrs[3]   = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            drive_op(~wrs[i], wrs[i], f3s[i], addrs[i], 32'h5555_AAAA, 1'b1, 5'd20 + 5'(i));
            sb_q.push_back('{32'h0, 5'd20 + 5'(i), 1'b0, 1'b1, 1'b0});
            @(negedge i_clk);
            n_cmp++;
            if (o_stall !== 1'b0 || o_dmem_req !== 1'b0) begin
                n_err++;
                $display("FAIL misaligned_%0d_idle: got stall=%b req=%b want 0/0", i, o_stall, o_dmem_req);
            end
            tick();
            i_valid = 1'b0;
            @(negedge i_clk);
            n_cmp++;
            if (o_dmem_req !== 1'b0) begin
                n_err++;
                $display("FAIL misaligned_%0d_noreq: got req=%b want 0", i, o_dmem_req);
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        drive_op(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1'b1, 5'd17);
        sb_q.push_back('{32'h0, 5'd17, 1'b0, 1'b0, 1'b1});
        tick();
        for (int w = 0; w < 16; w++) begin
            @(negedge i_clk);
            if (o_dmem_req === 1'b1) req_cycles++;
            n_cmp++;
            if (o_stall !== (w != 15)) begin
                n_err++;
                $display("FAIL timeout_stall[%0d]: got %b want %b", w, o_stall, (w != 15));
            end
            tick();
        end
        i_valid = 1'b0;
        n_cmp++;
        if (req_cycles != 16) begin
            n_err++;
            $display("FAIL timeout_req_len: got %0d req cycles want 16", req_cycles);
        end
        @(negedge i_clk);
        n_cmp++;
        if (o_dmem_req !== 1'b0 || o_MEM_bus_err !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_end: got req=%b bus_err=%b want 0/1", o_dmem_req, o_MEM_bus_err);
        end
        tick();
        i_dmem_ack   = 1'b1;
        i_dmem_rdata = 32'hFFFF_0000;
        repeat (2) begin
            tick();
            n_cmp++;
            if (o_MEM_valid !== 1'b0) begin
                n_err++;
                $display("FAIL stray_ack: got valid=%b want 0", o_MEM_valid);
            end
        end
        i_dmem_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_bus();
        drive_op(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 1'b1, 5'd25);
        tick();
        @(negedge i_clk);
        n_cmp++;
        if (o_dmem_req !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_pre: got req=%b want 1", o_dmem_req);
        end
        #1 i_reset_n = 1'b0;
        #1;
        n_cmp++;
        if (o_dmem_req !== 1'b0 || o_stall !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_async: got req=%b stall=%b want 0/0", o_dmem_req, o_stall);
        end
        i_dmem_ack = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        i_reset_n = 1'b1;
        @(negedge i_clk);
        n_cmp++;
        if ({o_MEM_valid, o_dmem_req, o_stall} !== 3'b000 || o_MEM_result !== 32'h0 ||
            o_dmem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL rst_mid_after: got valid=%b req=%b stall=%b result=%h addr=%h want zeros",
                     o_MEM_valid, o_dmem_req, o_stall, o_MEM_result, o_dmem_addr);
        end
        tick();
        i_dmem_ack = 1'b0;
        drive_op(1'b0, 1'b0, 3'b010, 32'hABCD_0123, 32'h0, 1'b1, 5'd26);
        sb_q.push_back('{32'hABCD_0123, 5'd26, 1'b1, 1'b0, 1'b0});
        tick();
        i_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_pass();
        test_loads();
        test_stores();
        test_misaligned();
        test_timeout();
        test_reset_mid_bus();
        repeat (3) tick();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d outstanding entries want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access pipeline stage directly downstream of the execute stage.
- Consumes the registered ALU result, used as address or data, and the store data from execute.
- Runs loads and stores over a single-outstanding req/ack data-memory bus, aligns and extends load data, and registers the writeback payload.
- Stalls upstream while a bus transaction is pending and flags misaligned or timed-out accesses.

Parameters:
DATA_WIDTH, 32, datapath width; byte-lane logic is fixed at 4 lanes, so only 32 is legal
REG_FILE_DEPTH, 32, register count; REG_FILE_ADDR = $clog2(REG_FILE_DEPTH)
TIMEOUT_CYCLES, 16, max cycles spent in BUS without ack before a bus error

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_valid  in  1  instruction present from execute
i_ctrl_mem_read  in  1  load
i_ctrl_mem_write  in  1  store; read and write both high is illegal and treated as read
i_ctrl_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
i_ctrl_reg_write  in  1  instruction writes rd
i_rd_addr  in  REG_FILE_ADDR  destination register
i_IE_result  in  DATA_WIDTH  ALU result (address or pass-through data)
i_IE_data_write  in  DATA_WIDTH  store data
o_stall  out  1  hold execute outputs stable
o_dmem_req  out  1  bus request
o_dmem_we  out  1  write enable
o_dmem_addr  out  DATA_WIDTH  word-aligned address, bits [1:0] = 0
o_dmem_wdata  out  DATA_WIDTH  lane-replicated store data
o_dmem_be  out  4  byte enables
i_dmem_ack  in  1  transfer complete; rdata valid on this cycle
i_dmem_rdata  in  DATA_WIDTH  read word
o_MEM_valid  out  1  writeback payload valid
o_MEM_result  out  DATA_WIDTH  load data or passed ALU result
o_MEM_rd_addr  out  REG_FILE_ADDR  destination register
o_MEM_reg_write  out  1  qualified register write
o_MEM_misaligned  out  1  misaligned access exception
o_MEM_bus_err  out  1  bus timeout exception

Behaviour:
- Reset (async, active-low): state IDLE, timeout counter 0, all o_dmem_* and o_MEM_* = 0. o_stall is combinational and therefore 0.
- Reset mid-transaction: o_dmem_req drops immediately.
- An ack arriving after reset, or any ack while in IDLE, is ignored.
- States: IDLE, BUS.
- IDLE, i_valid with no mem op:
  - Output register captures i_IE_result, i_rd_addr and i_ctrl_reg_write with valid=1 on the next edge.
  - Latency is 1 cycle; o_stall = 0.
- IDLE, i_valid with a mem op and aligned address:
  - o_stall = 1.
  - Latch the request: addr & ~3, we, be, wdata, funct3, addr[1:0], rd and reg_write.
  - Next state BUS; o_MEM_valid = 0 on the next edge (bubble).
- IDLE, i_valid with a misaligned mem op:
  - Misaligned means W with addr[1:0] != 0, or H/HU with addr[0] != 0.
  - No bus request is issued.
  - Output valid=1, misaligned=1, reg_write=0, result=0 next edge; o_stall = 0.
- BUS state:
  - o_dmem_req = 1; addr, we, be and wdata stay stable until ack.
  - o_stall = !i_dmem_ack.
  - Counter increments each cycle without ack.
- BUS with i_dmem_ack:
  - Output valid=1; result = extended load data for reads, 0 for stores.
  - reg_write = latched reg_write && read.
  - Return to IDLE; counter cleared.
  - Upstream advances on this same edge.
  - Minimum memory-op latency is 2 cycles (accept, then ack).
- BUS, counter == TIMEOUT_CYCLES-1, no ack:
  - Drop req; output valid=1, bus_err=1, reg_write=0, result=0.
  - o_stall = 0 on that cycle; return to IDLE.
  - If ack and terminal count occur on the same cycle, ack wins.
- i_valid=0 in IDLE: output valid=0 next edge; other output fields hold.
- Store lanes:
  - SB: wdata = {4{data[7:0]}}, be = 4'b0001 << off.
  - SH: wdata = {2{data[15:0]}}, be = 4'b0011 << off.
  - SW: be = 4'b1111.
- Load extraction:
  - byte = rdata[8*off +: 8]; half = rdata[16*off[1] +: 16].
  - B and H sign-extend; BU and HU zero-extend; W passes through.
- Exception flags are 1-cycle pulses qualified with o_MEM_valid.

Decomposition:
- Package mem_stage_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state enum {IDLE, BUS};
  - byte-enable and misalignment functions.
- Sub-module load_align: combinational funct3 plus offset plus rdata to extended 32-bit result, unit-tested standalone.

Test Plan:
- Non-mem op, i_IE_result=0x1234_5678, rd=5, reg_write=1 -> next cycle o_MEM_valid=1, result=0x12345678, rd=5, o_stall never 1.
- LB addr=0x103, rdata=0x80AA_BBCC, ack in first BUS cycle:
  - o_dmem_addr=0x100, be=0, we=0;
  - result=0xFFFF_FF80; the same access as LBU gives 0x0000_0080;
  - stall high exactly 1 cycle.
- SH addr=0x202, data=0xDEAD_BEEF, ack after 3 wait cycles:
  - wdata=0xBEEF_BEEF, be=4'b1100, addr=0x200 stable across all 4 BUS cycles;
  - reg_write=0.
- LW addr=0x101 -> no o_dmem_req; next cycle valid=1, misaligned=1, reg_write=0.
- LW with ack never asserted, TIMEOUT_CYCLES=16:
  - req high for 16 cycles, then valid=1, bus_err=1;
  - a later stray ack is ignored, with no valid pulse.
- i_reset_n low in the middle of BUS -> o_dmem_req and o_stall low immediately without waiting for a clock edge; after release, state is IDLE and outputs are 0.
